// File: rtl/switch_debounce.sv
// Two-flop synchronizer feeding a four-state debounce FSM: db_level only follows
// the synchronized switch after it has held a new value for CNT_MAX+1 sampled cycles.
module switch_debounce #(
    parameter int CNT_MAX = 1_000_000,
    parameter int CNT_W   = $clog2(CNT_MAX)
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    output logic db_level,
    output logic settling
);

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync0_q;
    logic             sync1_q;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             db_level_q;
    logic             db_level_d;
    logic             settling_q;
    logic             settling_d;

    // Next-state, counter and Moore output decode; outputs come from state_d so they register with the state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ZERO: begin
                if (sync1_q) begin
                    state_d = WAIT1;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = ZERO;
                end
            end
            WAIT1: begin
                if (!sync1_q) begin
                    state_d = ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ONE: begin
                if (!sync1_q) begin
                    state_d = WAIT0;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = ONE;
                end
            end
            WAIT0: begin
                if (sync1_q) begin
                    state_d = ONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ZERO;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
        db_level_d = (state_d == ONE) || (state_d == WAIT0);
        settling_d = (state_d == WAIT1) || (state_d == WAIT0);
    end

    // Synchronizer, FSM state, stability counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync0_q    <= 1'b0;
            sync1_q    <= 1'b0;
            state_q    <= ZERO;
            cnt_q      <= {CNT_W{1'b0}};
            db_level_q <= 1'b0;
            settling_q <= 1'b0;
        end else begin
            sync0_q    <= sw;
            sync1_q    <= sync0_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            db_level_q <= db_level_d;
            settling_q <= settling_d;
        end
    end

    assign db_level = db_level_q;
    assign settling = settling_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Directed and randomized checks of switch_debounce against a run-length model:
// db_level flips once the synchronized input has disagreed with it for CNT_MAX+1 edges.
module tb_switch_debounce;

    localparam int CNT_MAX = 4;
    localparam int LAT     = CNT_MAX + 3;

    logic clk = 1'b0;
    logic reset;
    logic sw;
    logic db_level;
    logic settling;

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic m_sync0;
    logic m_sync1;
    logic m_db;
    int   m_run;

    always #5 clk = ~clk;

    switch_debounce #(.CNT_MAX(CNT_MAX)) dut (
        .clk      (clk),
        .reset    (reset),
        .sw       (sw),
        .db_level (db_level),
        .settling (settling)
    );

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle, advance the model across the edge, then compare both outputs.
    task automatic step(input logic sw_v, input logic rst_v, input string tag);
        sw    = sw_v;
        reset = rst_v;
        @(posedge clk);
        if (rst_v) begin
            m_sync0 = 1'b0;
            m_sync1 = 1'b0;
            m_db    = 1'b0;
            m_run   = 0;
        end else begin
            if (m_sync1 != m_db) begin
                m_run++;
                if (m_run == CNT_MAX + 1) begin
                    m_db  = ~m_db;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_sync1 = m_sync0;
            m_sync0 = sw_v;
        end
        #1;
        check_bit({tag, "_db"}, db_level, m_db);
        check_bit({tag, "_settling"}, settling, (m_run != 0) ? 1'b1 : 1'b0);
    endtask

    // Hold sw and count edges until db_level changes; bounded by the cycle budget.
    task automatic measure(input logic sw_v, input string tag);
        logic start;
        int   n;
        start = db_level;
        n     = -1;
        for (int i = 1; i <= LAT + 5; i++) begin
            step(sw_v, 1'b0, tag);
            if (n < 0 && db_level !== start) begin
                n = i;
            end
        end
        check_int({tag, "_latency"}, n, LAT);
    endtask

    task automatic hold(input logic sw_v, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            step(sw_v, 1'b0, tag);
        end
    endtask

    initial begin
        logic saw_settle;
        logic cur;
        int   run_len;

        m_sync0 = 1'b0;
        m_sync1 = 1'b0;
        m_db    = 1'b0;
        m_run   = 0;
        sw      = 1'b1;
        reset   = 1'b1;

        // reset held two cycles with the switch already pressed
        step(1'b1, 1'b1, "rst0");
        step(1'b1, 1'b1, "rst1");
        check_bit("rst_db_const", db_level, 1'b0);
        check_bit("rst_settling_const", settling, 1'b0);
        measure(1'b1, "rst_rise");

        // clean release then clean press
        measure(1'b0, "release");
        measure(1'b1, "press");
        measure(1'b0, "release2");

        // bounce 1,0,1,0 in 2-cycle pulses, then hold 1
        hold(1'b1, 2, "bounce");
        hold(1'b0, 2, "bounce");
        hold(1'b1, 2, "bounce");
        hold(1'b0, 2, "bounce");
        check_bit("bounce_db_low", db_level, 1'b0);
        measure(1'b1, "bounce_final");

        // 4-cycle low glitch while in ONE
        saw_settle = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step((i < 4) ? 1'b0 : 1'b1, 1'b0, "glitch_lo");
            if (settling === 1'b1) saw_settle = 1'b1;
        end
        check_bit("glitch_lo_db_held", db_level, 1'b1);
        check_bit("glitch_lo_settle_pulse", saw_settle, 1'b1);

        measure(1'b0, "release3");

        // 4-cycle high glitch while in ZERO
        saw_settle = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step((i < 4) ? 1'b1 : 1'b0, 1'b0, "glitch_hi");
            if (settling === 1'b1) saw_settle = 1'b1;
        end
        check_bit("glitch_hi_db_held", db_level, 1'b0);
        check_bit("glitch_hi_settle_pulse", saw_settle, 1'b1);

        // reset pulse mid-settle, switch held high throughout
        hold(1'b1, 5, "midrst");
        check_bit("midrst_settling_before", settling, 1'b1);
        step(1'b1, 1'b1, "midrst_pulse");
        check_bit("midrst_db_in_reset", db_level, 1'b0);
        measure(1'b1, "midrst_rise");

        // reset while db_level is high forces it low
        step(1'b1, 1'b1, "rst_high");
        check_bit("rst_high_db", db_level, 1'b0);
        hold(1'b1, LAT + 2, "post_rst_high");

        // randomized runs with occasional reset, checked against the model each cycle
        cur = 1'b0;
        for (int k = 0; k < 120; k++) begin
            cur     = ~cur;
            run_len = $urandom_range(1, 8);
            for (int j = 0; j < run_len; j++) begin
                step(cur, ($urandom_range(0, 60) == 0) ? 1'b1 : 1'b0, "rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
